mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store access unit between the multicycle RV32I controller/datapath and the unified memory. It accepts one load or store request, performs byte-lane alignment, write-strobe generation and load sign/zero extension, and runs a request/acknowledge handshake with a variable-latency memory. It reports completion, misalignment and timeout faults back to the controller, which holds in its memory state until `done`.

## Interface

- TIMEOUT, 16, max cycles `mem_req` stays high without `mem_ack` before abort; legal range 1..255
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req  input  1  access request from controller; sampled only in IDLE
- we  input  1  1 = store, 0 = load; sampled with `req`
- funct3  input  3  RV32I width/sign code; sampled with `req`
- addr  input  32  byte address; sampled with `req`
- wdata  input  32  store data, LSB-aligned; sampled with `req`
- rdata  output  32  extended load result
- busy  output  1  access in flight (ACCESS state)
- done  output  1  one-cycle completion pulse
- err  output  1  fault flag, valid only while `done`=1
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  memory write enable
- mem_addr  output  32  word address, `{addr[31:2],2'b00}`
- mem_wstrb  output  4  byte write strobes
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  memory read word, valid when `mem_ack`=1
- mem_ack  input  1  memory acknowledge

## Operation

- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: when `req`=1, latch `we`, `funct3`, `addr`, `wdata`.
  - Legality: loads accept funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores accept 000 SB, 001 SH, 010 SW. Any other code is illegal.
  - Misalignment: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal or misaligned request goes to RESP with err=1. No memory transaction occurs.
  - Otherwise go to ACCESS and clear the timeout counter.
- ACCESS: `mem_req`=1. `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata` are driven from latched values and stay stable throughout.
  - On `mem_ack`=1: go to RESP with err=0. A load captures the extended result into `rdata`.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ack, go to RESP with err=1 and leave `rdata` unchanged.
  - If ack arrives in the expiry cycle, the ack wins.
- RESP: `done`=1 for exactly one cycle, then IDLE. `req` is ignored in RESP.
- Stores:
  - SB: `mem_wdata`={4{wdata[7:0]}}, `mem_wstrb`=4'b0001<<addr[1:0].
  - SH: `mem_wdata`={2{wdata[15:0]}}, `mem_wstrb`=addr[1]?4'b1100:4'b0011.
  - SW: `mem_wdata`=wdata, `mem_wstrb`=4'b1111.
- Loads: `mem_we`=0, `mem_wstrb`=0. Shift `mem_rdata` right by 8*addr[1:0]. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- `rdata` holds its value until the next successful load completes.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing

- Reset (asynchronous, any state): state←IDLE. `rdata`, `busy`, `done`, `err`, `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata` all ←0 immediately. An in-flight access is dropped; a late `mem_ack` is ignored.
- All outputs are registered or decoded from registered state. There are no combinational input→output paths.
- Cycle numbering:
  - Cycle 0: `req` sampled.
  - Cycles 1..k: `mem_req`=1 and `busy`=1.
  - `mem_ack` is sampled at cycle k.
  - Cycle k+1: `done`=1 and `rdata` is valid.
- Minimum legal-access latency is `req`→`done` = 2 cycles (ack at cycle 1). The next `req` can be accepted at cycle k+2.
- Fault latency: `done`/`err` at cycle 1, and `mem_req` is never asserted.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles (1..TIMEOUT), then `done`/`err` at cycle TIMEOUT+1.
- Throughput: at most one access per 3 cycles.

## Test plan

- LB addr=0x103, mem_rdata=0x80FF_1234, ack at cycle 1 → mem_addr=0x100, mem_wstrb=0, done at cycle 2, rdata=0xFFFF_FF80, err=0.
- LHU addr=0x202, mem_rdata=0xBEEF_0000, ack at cycle 3 → busy cycles 1–3, done at cycle 4, rdata=0x0000_BEEF. Repeat with LH → rdata=0xFFFF_BEEF.
- SB addr=0x31, wdata=0x1234_56AB → mem_we=1, mem_wstrb=4'b0010, mem_wdata=0xABAB_ABAB. SH addr=0x32 → strobe 4'b1100. Both hold stable until ack.
- LW addr=0x41 and funct3=3'b011 → done/err at cycle 1, mem_req never high, rdata unchanged.
- TIMEOUT=4, no ack → mem_req high cycles 1–4, done/err at cycle 5. Ack at cycle 4 instead → err=0 and data captured.
- Reset asserted at cycle 2 of an access → mem_req/busy drop in the same cycle, all outputs 0. A later ack is ignored, and a new request after reset completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store access unit: aligns and strobes stores, extends loads, and runs a
// req/ack handshake with a variable-latency memory, reporting done/err upstream.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    logic ok;
    if (st) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [31:0] s;
    logic [31:0] r;
    s = rd >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Next-state and output register computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d  = we;
          f3_d  = funct3;
          off_d = addr[1:0];
          if (!is_legal(we, funct3) || is_misaligned(funct3, addr[1:0])) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = we ? store_strobe(funct3, addr[1:0]) : 4'b0000;
            mem_wdata_d = we ? store_lanes(funct3, wdata) : 32'h0000_0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Ack is checked first so an ack in the expiry cycle still succeeds.
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          state_d     = ST_RESP;
          done_d      = 1'b1;
          err_d       = !mem_ack;
          mem_req_d   = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
          if (mem_ack && !we_q) begin
            rdata_d = load_extend(f3_q, off_q, mem_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rdata_q     <= 32'h0000_0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = mem_req_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q & we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued when a
// request is driven and compared when done pulses.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_rdata = 32'h0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One access; ack_cyc=0 means the memory never answers. Faults expect no mem_req.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] mrd, input int ack_cyc,
                           input logic [31:0] e_addr, input logic [3:0] e_strb,
                           input logic [31:0] e_wdata, input logic e_err,
                           input logic [31:0] e_rdata, input int e_done);
    exp_t e;
    int   c;
    bit   seen;
    sb.push_back('{err: e_err, rdata: e_rdata, done_cyc: e_done});
    @(negedge clk);
    req = 1'b1; we = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    seen = 1'b0;
    for (c = 1; c <= 40 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        mem_ack = 1'b0;
        e = sb.pop_front();
        check_val("done_cycle", c, e.done_cyc);
        check_val("err", {31'b0, err}, {31'b0, e.err});
        check_val("rdata", rdata, e.rdata);
        check_val("mem_req_at_done", {31'b0, mem_req}, 32'd0);
      end else begin
        check_val("mem_req", {31'b0, mem_req}, 32'd1);
        check_val("busy", {31'b0, busy}, 32'd1);
        check_val("mem_we", {31'b0, mem_we}, {31'b0, st});
        check_val("mem_addr", mem_addr, e_addr);
        check_val("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_strb});
        check_val("mem_wdata", mem_wdata, e_wdata);
        if (c == ack_cyc) begin
          mem_ack = 1'b1; mem_rdata = mrd;
        end else begin
          mem_ack = 1'b0; mem_rdata = 32'hDEAD_0000 + c;
        end
        @(negedge clk);
      end
    end
    if (!seen) check_val("done_wait_expired", 32'd0, 32'd1);
    model_rdata = e_rdata;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_ctl", {27'b0, busy, done, err, mem_req, mem_we}, 32'h0);
    check_val("rst_mem", mem_addr | mem_wdata | {28'b0, mem_wstrb}, 32'h0);
    reset = 1'b0;

    // Loads with extension from each lane.
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1, 32'h100, 4'h0, 32'h0, 1'b0, 32'hFFFF_FF80, 2);
    do_access(1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0000, 3, 32'h200, 4'h0, 32'h0, 1'b0, 32'h0000_BEEF, 4);
    do_access(1'b0, 3'b001, 32'h202, 32'h0, 32'hBEEF_0000, 3, 32'h200, 4'h0, 32'h0, 1'b0, 32'hFFFF_BEEF, 4);
    do_access(1'b0, 3'b100, 32'h61, 32'h0, 32'h0000_9A00, 2, 32'h60, 4'h0, 32'h0, 1'b0, 32'h0000_009A, 3);
    do_access(1'b0, 3'b000, 32'h62, 32'h0, 32'h007F_0000, 1, 32'h60, 4'h0, 32'h0, 1'b0, 32'h0000_007F, 2);
    // Stores leave rdata untouched.
    do_access(1'b1, 3'b000, 32'h31, 32'h1234_56AB, 32'h0, 3, 32'h30, 4'b0010, 32'hABAB_ABAB, 1'b0, model_rdata, 4);
    do_access(1'b1, 3'b001, 32'h32, 32'h1234_56AB, 32'h0, 2, 32'h30, 4'b1100, 32'h56AB_56AB, 1'b0, model_rdata, 3);
    do_access(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 32'h0, 1, 32'h40, 4'b1111, 32'hDEAD_BEEF, 1'b0, model_rdata, 2);
    // Misaligned and illegal requests fault at cycle 1 without a memory transaction.
    do_access(1'b0, 3'b010, 32'h41, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b1, model_rdata, 1);
    do_access(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b1, model_rdata, 1);
    do_access(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b1, model_rdata, 1);
    do_access(1'b1, 3'b001, 32'h43, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b1, model_rdata, 1);
    // Timeout, then ack landing in the expiry cycle.
    do_access(1'b0, 3'b010, 32'h50, 32'h0, 32'h0, 0, 32'h50, 4'h0, 32'h0, 1'b1, model_rdata, 5);
    do_access(1'b0, 3'b010, 32'h50, 32'h0, 32'h1234_5678, 4, 32'h50, 4'h0, 32'h0, 1'b0, 32'h1234_5678, 5);

    // Reset mid-access: everything drops, a late ack is ignored.
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    req = 1'b0;
    check_val("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("async_rst_ctl", {27'b0, busy, done, err, mem_req, mem_we}, 32'h0);
    check_val("async_rst_rdata", rdata, 32'h0);
    check_val("async_rst_mem", mem_addr | mem_wdata | {28'b0, mem_wstrb}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("late_ack_done", {30'b0, done, mem_req}, 32'h0);
    @(negedge clk);
    check_val("late_ack_rdata", rdata, 32'h0);
    model_rdata = 32'h0;
    do_access(1'b0, 3'b010, 32'h70, 32'h0, 32'hCAFE_F00D, 2, 32'h70, 4'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
